// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline hazard controller: FSM state encoding,
//   register-index width, and the bundle of per-stage control outputs together
//   with the fixed patterns the controller drives.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  // One bundle for every PC/stage-register control so the decode can assign
  // whole patterns at once.
  typedef struct packed {
    logic pc_en;
    logic pc_redirect;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } ctrl_t;

  // Normal flow: everything advances, nothing flushed.
  localparam ctrl_t CTRL_RUN    = 9'b1_0_1111_000;
  // Held in reset: nothing advances, every stage fed a bubble.
  localparam ctrl_t CTRL_RESET  = 9'b0_0_0000_111;
  // Data memory busy: whole pipeline holds, PC included.
  localparam ctrl_t CTRL_FREEZE = 9'b0_0_0000_000;
  // Branch/jump taken at MEM: load target, squash the three younger stages.
  localparam ctrl_t CTRL_TAKE   = 9'b1_1_1111_111;
  // Load-use bubble: PC and IF/ID hold, ID/EX gets a bubble, older stages drain.
  localparam ctrl_t CTRL_LSTALL = 9'b0_0_0111_010;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect
//   Combinational load-use hazard compare between the instruction in ID and
//   the load sitting in ID/EX.
//   Ports:
//     id_rs, id_rt   source registers of the ID instruction
//     id_uses_rt     ID instruction actually reads rt
//     ex_rd          destination of the ID/EX instruction
//     ex_mem_read    ID/EX instruction is a load
//     load_use       hazard present this cycle
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rd == id_rs);
  assign rt_match = id_uses_rt & (ex_rd == id_rt);

  // A load into the zero register never produces a usable value, so it
  // cannot create a dependency.
  assign load_use = ex_mem_read & (ex_rd != ZERO_REG) & (rs_match | rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central sequencer for the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB registers.
//   Inserts load-use bubbles, applies branch/jump redirects resolved at MEM,
//   freezes the pipeline during multi-cycle data-memory accesses, counts
//   stalled cycles and flags over-long memory waits.
//   Ports:
//     clk, rst_n                 clock, synchronous active-low reset
//     id_rs, id_rt, id_uses_rt   ID instruction operands
//     ex_rd, ex_mem_read         load in ID/EX
//     mem_branch, mem_zero,
//     mem_jump                   control-flow resolution in EX/MEM
//     dmem_req, dmem_ready       data-memory handshake
//     pc_en, pc_redirect         PC enable and target select
//     *_en, *_flush              stage register enables / bubble inserts
//     stall_cycles               saturating count of cycles with pc_en=0
//     mem_err                    sticky memory-wait timeout
//   All control outputs are combinational from state and inputs.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_jump,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_err
);

  // Wide enough that the saturated value always exceeds MEM_TIMEOUT-1.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [2:0] BUB_INIT = 3'(LOAD_BUBBLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;
  state_e            eff_state;
  logic [2:0]        bubble_q, bubble_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_now;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              err_q, err_d;
  ctrl_t             ctrl;

  logic load_use;
  logic take;
  logic dwait;

  load_use_detect u_load_use_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign take  = (mem_branch & mem_zero) | mem_jump;
  assign dwait = dmem_req & ~dmem_ready;

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    bubble_d = bubble_q;
    wait_d   = wait_q;
    err_d    = err_q;
    ctrl     = CTRL_RUN;

    // Wait count only carries over while already waiting; a fresh wait
    // starts from zero so the entry cycle counts as the first wait cycle.
    wait_now = (state_q == MEM_WAIT) ? wait_q : '0;

    // On the cycle a memory wait ends, behave exactly like the state we
    // came from, so pending redirects and remaining bubbles take effect.
    eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

    if (dwait) begin
      ctrl    = CTRL_FREEZE;
      state_d = MEM_WAIT;
      if (state_q != MEM_WAIT) begin
        ret_d = state_q;
      end
      wait_d = (&wait_now) ? wait_now : wait_now + 1'b1;
      if (wait_now >= WAIT_LIMIT) begin
        err_d = 1'b1;
      end
    end else begin
      wait_d = '0;
      case (eff_state)
        RUN: begin
          state_d = RUN;
          if (take) begin
            ctrl = CTRL_TAKE;
          end else if (load_use) begin
            ctrl     = CTRL_LSTALL;
            bubble_d = BUB_INIT;
            if (LOAD_BUBBLES > 1) begin
              state_d = LOAD_STALL;
            end
          end
        end
        LOAD_STALL: begin
          if (take) begin
            // Older control-flow change squashes the stalled instruction anyway.
            ctrl     = CTRL_TAKE;
            bubble_d = 3'd0;
            state_d  = RUN;
          end else begin
            // bubble_q holds the bubbles still owed including this one.
            ctrl = CTRL_LSTALL;
            if (bubble_q <= 3'd1) begin
              bubble_d = 3'd0;
              state_d  = RUN;
            end else begin
              bubble_d = bubble_q - 3'd1;
              state_d  = LOAD_STALL;
            end
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end

    if (!rst_n) begin
      ctrl = CTRL_RESET;
    end

    stall_d = stall_q;
    if (!ctrl.pc_en && !(&stall_q)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      ret_q    <= RUN;
      bubble_q <= 3'd0;
      wait_q   <= '0;
      stall_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      bubble_q <= bubble_d;
      wait_q   <= wait_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign pc_redirect  = ctrl.pc_redirect;
  assign ifid_en      = ctrl.ifid_en;
  assign idex_en      = ctrl.idex_en;
  assign exmem_en     = ctrl.exmem_en;
  assign memwb_en     = ctrl.memwb_en;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_flush   = ctrl.idex_flush;
  assign exmem_flush  = ctrl.exmem_flush;
  assign stall_cycles = stall_q;
  assign mem_err      = err_q;

endmodule
